mac_pipeline: RTL and testbench

- Parametrised multiply-accumulate datapath that replaces the fixed 16/32-bit T/P/accumulator chain of the DSP core.
- Adds generic operand and accumulator widths, a registered multiplier stage with a hazard interlock, selectable product shift, saturation (overflow mode) and a sticky overflow flag.
- Sits between the data bus / instruction decoder and the accumulator shifter. Takes one opcode per accepted cycle.

---
 rtl/mac_pkg.sv | 35 +++
 rtl/mac_mult_stage.sv | 38 +++
 rtl/mac_pipeline.sv | 124 ++++++++++++
 tb/tb_mac_pipeline.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: opcode and product-shift
// encodings, plus the saturation-constant helper.
package mac_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LT   = 3'd1;
  localparam logic [2:0] OP_MPY  = 3'd2;
  localparam logic [2:0] OP_APAC = 3'd3;
  localparam logic [2:0] OP_SPAC = 3'd4;
  localparam logic [2:0] OP_LTA  = 3'd5;
  localparam logic [2:0] OP_MAC  = 3'd6;
  localparam logic [2:0] OP_ZAC  = 3'd7;

  localparam logic [1:0] PM_NONE = 2'd0;
  localparam logic [1:0] PM_SL1  = 2'd1;
  localparam logic [1:0] PM_SL4  = 2'd2;
  localparam logic [1:0] PM_SR6  = 2'd3;

  // Widest accumulator the helper can describe.
  localparam int unsigned SAT_W = 128;

  // Signed max (neg = 0) or signed min (neg = 1) of a w-bit word,
  // right-aligned in SAT_W bits; callers truncate to their width.
  function automatic logic [SAT_W-1:0] sat_value(input int unsigned w, input logic neg);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w - 1; i++) r[i] = 1'b1;
    if (neg) begin
      r = ~r;
      for (int unsigned i = w; i < SAT_W; i++) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered signed WIDTH x WIDTH multiplier with a valid bit.
//   clk, reset : clock, asynchronous active-high reset
//   start      : capture a*b this edge
//   a, b       : signed operands
//   busy       : stage holds an unretired product
//   p_we       : write enable for the P register (product retires)
//   product    : registered 2*WIDTH-bit product
module mac_mult_stage #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      busy,
  output logic                      p_we,
  output logic signed [2*WIDTH-1:0] product
);

  logic                      valid;
  logic signed [2*WIDTH-1:0] prod_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      prod_q <= '0;
    end else begin
      valid <= start;
      if (start) prod_q <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
    end
  end

  assign busy    = valid;
  assign p_we    = valid;
  assign product = prod_q;

endmodule

// File: rtl/mac_pipeline.sv
// Parametrised multiply-accumulate datapath (T / P / ACC) with a
// registered multiplier, P-reader interlock, product shift, optional
// saturation and a sticky overflow flag.
//   clk, reset      : clock, asynchronous active-high reset
//   op_valid/ready  : op handshake; ready drops for P readers while busy
//   op_code, operand: operation and signed data-bus operand
//   ovm             : 1 = saturate ACC on overflow, 0 = wrap
//   pm              : product shift (none, <<1, <<4, >>>6)
//   clr_ovf         : clears ovf_flag (an overflow on the same edge wins)
//   t_out, p_out, acc_out, ovf_flag, busy : architectural state
module mac_pipeline
  import mac_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op_code,
  input  logic [WIDTH-1:0]     operand,
  input  logic                 ovm,
  input  logic [1:0]           pm,
  input  logic                 clr_ovf,
  output logic [WIDTH-1:0]     t_out,
  output logic [2*WIDTH-1:0]   p_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf_flag,
  output logic                 busy
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_value(ACC_WIDTH, 1'b0));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_value(ACC_WIDTH, 1'b1));

  logic signed [WIDTH-1:0]     t_q, t_d;
  logic signed [2*WIDTH-1:0]   p_q, product;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, p_ext, shp, acc_arith;
  logic signed [ACC_WIDTH:0]   acc_x, shp_x, sum;
  logic                        ovf_q, ovf_d, ovf_now, acc_op;
  logic                        p_reader, accept, mul_start, p_we, mul_busy;

  mac_mult_stage #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (t_q),
    .b      (operand),
    .busy   (mul_busy),
    .p_we   (p_we),
    .product(product)
  );

  always_comb begin
    p_reader  = (op_code == OP_APAC) || (op_code == OP_SPAC) ||
                (op_code == OP_LTA)  || (op_code == OP_MAC);
    op_ready  = !(mul_busy && p_reader);
    accept    = op_valid && op_ready;
    mul_start = accept && ((op_code == OP_MPY) || (op_code == OP_MAC));
  end

  // Product shift and (ACC_WIDTH+1)-bit accumulate with overflow detect.
  always_comb begin
    p_ext = ACC_WIDTH'(p_q);
    unique case (pm)
      PM_SL1:  shp = p_ext <<< 1;
      PM_SL4:  shp = p_ext <<< 4;
      PM_SR6:  shp = p_ext >>> 6;
      default: shp = p_ext;
    endcase
    acc_x = (ACC_WIDTH+1)'(acc_q);
    shp_x = (ACC_WIDTH+1)'(shp);
    sum   = (op_code == OP_SPAC) ? acc_x - shp_x : acc_x + shp_x;
    ovf_now = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    if (ovf_now && ovm) acc_arith = sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    else                acc_arith = sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    t_d    = t_q;
    acc_d  = acc_q;
    acc_op = 1'b0;
    if (accept) begin
      unique case (op_code)
        OP_LT:   t_d = operand;
        OP_APAC, OP_SPAC, OP_MAC: begin
          acc_d  = acc_arith;
          acc_op = 1'b1;
        end
        OP_LTA: begin
          t_d    = operand;
          acc_d  = acc_arith;
          acc_op = 1'b1;
        end
        OP_ZAC:  acc_d = '0;
        default: ;
      endcase
    end
    if (acc_op && ovf_now) ovf_d = 1'b1;
    else if (clr_ovf)      ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      if (p_we) p_q <= product;
    end
  end

  assign t_out    = t_q;
  assign p_out    = p_q;
  assign acc_out  = acc_q;
  assign ovf_flag = ovf_q;
  assign busy     = mul_busy;

endmodule

// File: tb/tb_mac_pipeline.sv
// Directed self-checking bench for mac_pipeline (default 16/32 widths).
module tb_mac_pipeline;

  localparam logic [2:0] NOP = 3'd0, LT = 3'd1, MPY = 3'd2, APAC = 3'd3,
                         SPAC = 3'd4, MAC = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [15:0] operand = '0;
  logic        ovm = 1'b0;
  logic [1:0]  pm = 2'd0;
  logic        clr_ovf = 1'b0;
  logic [15:0] t_out;
  logic [31:0] p_out;
  logic [31:0] acc_out;
  logic        ovf_flag;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int st, tot;

  mac_pipeline #(.WIDTH(16), .ACC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .operand(operand), .ovm(ovm), .pm(pm),
    .clr_ovf(clr_ovf), .t_out(t_out), .p_out(p_out), .acc_out(acc_out),
    .ovf_flag(ovf_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op from the falling edge, count cycles with op_ready low,
  // return #1 after the accepting rising edge.
  task automatic issue(input logic [2:0] code, input logic [15:0] val, output int stalls);
    stalls = 0;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; operand = val;
    #1;
    while (!op_ready && stalls < 8) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!op_ready) check("ready_timeout", {63'd0, op_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP; clr_ovf = clr;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP; pm = 2'd0; ovm = 1'b0; clr_ovf = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves ACC = 0x7FFF_FFF0, ovf cleared and P = 0x20 about to retire.
  task automatic build_near_max();
    int s;
    do_reset();
    issue(LT, 16'h8000, s);
    issue(MPY, 16'h8000, s);          // P = 0x4000_0000
    pm = 2'd1;
    issue(APAC, 16'h0, s);            // shp = 0x8000_0000 -> ACC = min
    pm = 2'd0;
    issue(LT, 16'd4, s);
    issue(MPY, 16'd4, s);             // P = 0x10
    issue(SPAC, 16'h0, s);            // min - 0x10 wraps
    check("build_acc", 64'(acc_out), 64'h7FFF_FFF0);
    check("build_ovf", 64'(ovf_flag), 64'd1);
    idle(1'b1);
    check("build_clr", 64'(ovf_flag), 64'd0);
    issue(LT, 16'd4, s);
    issue(MPY, 16'd8, s);             // P = 0x20
  endtask

  initial begin
    #12;
    check("rst_t", 64'(t_out), 64'd0);
    check("rst_p", 64'(p_out), 64'd0);
    check("rst_acc", 64'(acc_out), 64'd0);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(op_ready), 64'd1);

    // LT 3, MPY 5, APAC: one bubble, then P = ACC = 15
    do_reset();
    issue(LT, 16'd3, st);
    issue(MPY, 16'd5, st);
    issue(APAC, 16'd0, st);
    check("apac_bubble", 64'(st), 64'd1);
    check("apac_p", 64'(p_out), 64'd15);
    check("apac_acc", 64'(acc_out), 64'd15);

    // Reset with an MPY in flight
    do_reset();
    issue(LT, 16'd3, st);
    issue(MPY, 16'd5, st);
    check("inflight_busy", 64'(busy), 64'd1);
    op_code = APAC;
    reset = 1'b1;
    #1;
    check("midrst_t", 64'(t_out), 64'd0);
    check("midrst_p", 64'(p_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(op_ready), 64'd1);
    op_valid = 1'b0; op_code = NOP;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_p_after", 64'(p_out), 64'd0);

    // Saturation with ovm = 1, then sticky-flag behaviour
    build_near_max();
    ovm = 1'b1;
    issue(APAC, 16'd0, st);
    check("sat_acc", 64'(acc_out), 64'h7FFF_FFFF);
    check("sat_ovf", 64'(ovf_flag), 64'd1);
    clr_ovf = 1'b1;
    issue(APAC, 16'd0, st);           // overflows again with clr_ovf high
    clr_ovf = 1'b0;
    check("sticky_set_wins", 64'(ovf_flag), 64'd1);
    check("sticky_acc", 64'(acc_out), 64'h7FFF_FFFF);
    idle(1'b1);
    check("sticky_clr", 64'(ovf_flag), 64'd0);

    // Same overflow with ovm = 0 wraps
    build_near_max();
    ovm = 1'b0;
    issue(APAC, 16'd0, st);
    check("wrap_acc", 64'(acc_out), 64'h8000_0010);
    check("wrap_ovf", 64'(ovf_flag), 64'd1);

    // Product shift: P = -128
    do_reset();
    issue(LT, 16'hFFF0, st);
    issue(MPY, 16'd8, st);
    pm = 2'd3;
    issue(APAC, 16'd0, st);
    check("shift_p", 64'(p_out), 64'hFFFF_FF80);
    check("shift_sr6", 64'(acc_out), 64'hFFFF_FFFE);
    pm = 2'd2;
    issue(SPAC, 16'd0, st);
    check("shift_sl4", 64'(acc_out), 64'd2046);
    check("shift_noovf", 64'(ovf_flag), 64'd0);
    pm = 2'd0;

    // MAC stream: T = 2, operands 1..4, then APAC
    do_reset();
    issue(LT, 16'd2, st);
    tot = 0;
    for (int i = 1; i <= 4; i++) begin
      issue(MAC, 16'(i), st);
      tot += st;
    end
    issue(APAC, 16'd0, st);
    tot += st;
    check("mac_acc", 64'(acc_out), 64'd20);
    check("mac_p", 64'(p_out), 64'd8);
    check("mac_bubbles", 64'(tot), 64'd4);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
